// File: rtl/vga_timing_pkg.sv
// Timing constants, counter/coordinate widths and colour field positions
// shared by the VGA scan driver and its alignment pipeline.
package vga_timing_pkg;

  // Default 640x480@60 Hz timing (pixels / lines)
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Derived totals and sync windows for the default timing
  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 800
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 525
  localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;                          // 656
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;                    // 751
  localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;                          // 490
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;                    // 491

  // Widths
  localparam int CNT_W = 10;
  localparam int POS_W = 11;
  localparam int RGB_W = 12;

  // Colour word field positions: [11:8]=R, [7:4]=G, [3:0]=B
  localparam int R_HI = 11;
  localparam int R_LO = 8;
  localparam int G_HI = 7;
  localparam int G_LO = 4;
  localparam int B_HI = 3;
  localparam int B_LO = 0;

  // Per-cycle raster attributes carried down the alignment pipeline.
  // hs/vs are 1 when the sync window is asserted, so an all-zero tag
  // means "blank, sync inactive" and is the natural cleared value.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } scan_tag_t;

  // Inclusive window test on a counter value
  function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register shift line with asynchronous active-low clear.
// dout is din delayed by exactly DEPTH clock edges.
module vga_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift din through DEPTH stages; clear every stage on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_scan_driver.sv
// VGA raster generator: h/v counters, coordinate publish to the renderers,
// and a latency-aligned registered output stage for sync and RGB pins.
module vga_scan_driver
  import vga_timing_pkg::*;
#(
  parameter int DATA_LAT = 3,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RGB_W-1:0] VGA_data,
  output logic [POS_W-1:0] VGA_xpos,
  output logic [POS_W-1:0] VGA_ypos,
  output logic             VGA_hs,
  output logic             VGA_vs,
  output logic [3:0]       VGA_r,
  output logic [3:0]       VGA_g,
  output logic [3:0]       VGA_b,
  output logic             frame_start
);

  // Counter limits and window bounds for the chosen timing
  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] HS_LO     = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_HI     = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_LO     = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_HI     = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] h_cnt_r;
  logic [CNT_W-1:0] v_cnt_r;
  logic             h_act_s;
  logic             v_act_s;
  scan_tag_t        tag_in_s;
  scan_tag_t        tag_out_s;

  // Raster counters: h wraps every line, v advances on the last pixel of a line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_r <= {CNT_W{1'b0}};
      v_cnt_r <= {CNT_W{1'b0}};
    end else if (h_cnt_r == H_LAST) begin
      h_cnt_r <= {CNT_W{1'b0}};
      if (v_cnt_r == V_LAST) begin
        v_cnt_r <= {CNT_W{1'b0}};
      end else begin
        v_cnt_r <= v_cnt_r + 10'd1;
      end
    end else begin
      h_cnt_r <= h_cnt_r + 10'd1;
    end
  end

  // Decode active/sync from the counter registers and publish coordinates;
  // gating by rst_n keeps coordinates and frame_start at 0 during reset
  always_comb begin
    h_act_s     = (h_cnt_r < H_ACT_END);
    v_act_s     = (v_cnt_r < V_ACT_END);
    tag_in_s.active = h_act_s && v_act_s;
    tag_in_s.hs     = in_window(h_cnt_r, HS_LO, HS_HI);
    tag_in_s.vs     = in_window(v_cnt_r, VS_LO, VS_HI);
    VGA_xpos    = {POS_W{1'b0}};
    VGA_ypos    = {POS_W{1'b0}};
    frame_start = 1'b0;
    if (rst_n && h_act_s && v_act_s) begin
      VGA_xpos = {1'b0, h_cnt_r} + 11'd1;
      VGA_ypos = {1'b0, v_cnt_r} + 11'd1;
    end else begin
      VGA_xpos = {POS_W{1'b0}};
      VGA_ypos = {POS_W{1'b0}};
    end
    if (rst_n && (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0)) begin
      frame_start = 1'b1;
    end else begin
      frame_start = 1'b0;
    end
  end

  // Delay the raster attributes so they meet the renderer's colour word
  vga_delay_line #(
    .WIDTH ($bits(scan_tag_t)),
    .DEPTH (DATA_LAT)
  ) u_align (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (tag_in_s),
    .dout  (tag_out_s)
  );

  // Output pins: sync and colour leave on the same edge, colour blanked
  // whenever the aligned pixel is outside the active region
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      VGA_hs <= 1'b1;
      VGA_vs <= 1'b1;
      VGA_r  <= 4'h0;
      VGA_g  <= 4'h0;
      VGA_b  <= 4'h0;
    end else begin
      VGA_hs <= ~tag_out_s.hs;
      VGA_vs <= ~tag_out_s.vs;
      if (tag_out_s.active) begin
        VGA_r <= VGA_data[R_HI:R_LO];
        VGA_g <= VGA_data[G_HI:G_LO];
        VGA_b <= VGA_data[B_HI:B_LO];
      end else begin
        VGA_r <= 4'h0;
        VGA_g <= 4'h0;
        VGA_b <= 4'h0;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_driver.sv
// Self-checking bench for vga_scan_driver. Three instances (DATA_LAT 3, 1, 8)
// share clock, reset and VGA_data; a reduced raster keeps runs short.
module tb_vga_scan_driver;

  localparam int HA = 16, HFP = 4, HSY = 6, HBP = 4;
  localparam int VA = 8,  VFP = 2, VSY = 2, VBP = 3;
  localparam int HT = HA + HFP + HSY + HBP;   // 30
  localparam int VT = VA + VFP + VSY + VBP;   // 15
  localparam int FT = HT * VT;                // 450

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] vga_data;
  logic [10:0] xpos [3];
  logic [10:0] ypos [3];
  logic        hs   [3];
  logic        vs   [3];
  logic [3:0]  r    [3];
  logic [3:0]  g    [3];
  logic [3:0]  b    [3];
  logic        fs   [3];

  int checks   = 0;
  int failures = 0;
  logic [11:0] data_hist [$];

  always #20 clk = ~clk;

  vga_scan_driver #(.DATA_LAT(3), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
                    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)) dut0 (
    .clk(clk), .rst_n(rst_n), .VGA_data(vga_data), .VGA_xpos(xpos[0]), .VGA_ypos(ypos[0]),
    .VGA_hs(hs[0]), .VGA_vs(vs[0]), .VGA_r(r[0]), .VGA_g(g[0]), .VGA_b(b[0]), .frame_start(fs[0]));

  vga_scan_driver #(.DATA_LAT(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
                    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)) dut1 (
    .clk(clk), .rst_n(rst_n), .VGA_data(vga_data), .VGA_xpos(xpos[1]), .VGA_ypos(ypos[1]),
    .VGA_hs(hs[1]), .VGA_vs(vs[1]), .VGA_r(r[1]), .VGA_g(g[1]), .VGA_b(b[1]), .frame_start(fs[1]));

  vga_scan_driver #(.DATA_LAT(8), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
                    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)) dut2 (
    .clk(clk), .rst_n(rst_n), .VGA_data(vga_data), .VGA_xpos(xpos[2]), .VGA_ypos(ypos[2]),
    .VGA_hs(hs[2]), .VGA_vs(vs[2]), .VGA_r(r[2]), .VGA_g(g[2]), .VGA_b(b[2]), .frame_start(fs[2]));

  // ---------------- reference model: raster position as a function of cycle index
  function automatic int lat_of(input int d);
    case (d)
      0:       return 3;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  function automatic int m_h(input int k); return k % HT;        endfunction
  function automatic int m_v(input int k); return (k / HT) % VT; endfunction
  function automatic bit m_active(input int k); return (m_h(k) < HA) && (m_v(k) < VA); endfunction
  function automatic bit m_hsync(input int k);
    return (m_h(k) >= HA + HFP) && (m_h(k) < HA + HFP + HSY);
  endfunction
  function automatic bit m_vsync(input int k);
    return (m_v(k) >= VA + VFP) && (m_v(k) < VA + VFP + VSY);
  endfunction
  function automatic int m_x(input int k); return m_active(k) ? m_h(k) + 1 : 0; endfunction
  function automatic int m_y(input int k); return m_active(k) ? m_v(k) + 1 : 0; endfunction

  // ---------------- stimulus helpers (no checking here)
  task automatic release_reset;
    @(negedge clk);
    rst_n = 1'b1;
    data_hist.delete();
    #1;
  endtask

  task automatic step(input logic [11:0] d);
    vga_data = d;
    data_hist.push_back(d);
    @(negedge clk);
    #1;
  endtask

  // ---------------- tests
  task automatic test_reset;
    rst_n    = 1'b0;
    vga_data = 12'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (xpos[d] !== 11'd0 || ypos[d] !== 11'd0)
        begin failures++; $display("FAIL reset_pos dut%0d got x=%0d y=%0d exp 0 0", d, xpos[d], ypos[d]); end
      checks++;
      if ({hs[d], vs[d], fs[d]} !== 3'b110)
        begin failures++; $display("FAIL reset_ctl dut%0d got hs/vs/fs=%b exp 110", d, {hs[d], vs[d], fs[d]}); end
      checks++;
      if ({r[d], g[d], b[d]} !== 12'h000)
        begin failures++; $display("FAIL reset_rgb dut%0d got %h exp 000", d, {r[d], g[d], b[d]}); end
    end
  endtask

  task automatic test_raster_random;
    int n, lat, fs_cnt, hs_low, vs_low;
    logic [11:0] exp_rgb;
    logic exp_hs, exp_vs;
    fs_cnt = 0; hs_low = 0; vs_low = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    for (int k = 0; k < 2 * FT + 10; k++) begin
      for (int d = 0; d < 3; d++) begin
        lat = lat_of(d);
        if (k >= lat + 1) begin
          n       = k - lat - 1;
          exp_rgb = m_active(n) ? data_hist[k-1] : 12'h000;
          exp_hs  = !m_hsync(n);
          exp_vs  = !m_vsync(n);
        end else begin
          exp_rgb = 12'h000; exp_hs = 1'b1; exp_vs = 1'b1;
        end
        checks++;
        if (xpos[d] !== 11'(m_x(k)))
          begin failures++; $display("FAIL xpos dut%0d k=%0d got=%0d exp=%0d", d, k, xpos[d], m_x(k)); end
        checks++;
        if (ypos[d] !== 11'(m_y(k)))
          begin failures++; $display("FAIL ypos dut%0d k=%0d got=%0d exp=%0d", d, k, ypos[d], m_y(k)); end
        checks++;
        if (fs[d] !== ((k % FT) == 0))
          begin failures++; $display("FAIL frame_start dut%0d k=%0d got=%b exp=%b", d, k, fs[d], (k % FT) == 0); end
        checks++;
        if ({hs[d], vs[d]} !== {exp_hs, exp_vs})
          begin failures++; $display("FAIL sync dut%0d k=%0d got=%b%b exp=%b%b", d, k, hs[d], vs[d], exp_hs, exp_vs); end
        checks++;
        if ({r[d], g[d], b[d]} !== exp_rgb)
          begin failures++; $display("FAIL rgb dut%0d k=%0d got=%h exp=%h", d, k, {r[d], g[d], b[d]}, exp_rgb); end
      end
      if (k >= 4 && k < 4 + FT) begin
        if (!hs[0]) hs_low++;
        if (!vs[0]) vs_low++;
      end
      if (k < 2 * FT && fs[0]) fs_cnt++;
      step(12'($urandom));
    end
    checks++;
    if (fs_cnt != 2)
      begin failures++; $display("FAIL frame_count got=%0d exp=2", fs_cnt); end
    checks++;
    if (hs_low != HSY * VT)
      begin failures++; $display("FAIL hs_low_per_frame got=%0d exp=%0d", hs_low, HSY * VT); end
    checks++;
    if (vs_low != VSY * HT)
      begin failures++; $display("FAIL vs_low_per_frame got=%0d exp=%0d", vs_low, VSY * HT); end
  endtask

  task automatic test_latency;
    logic [11:0] rgb0, rgb1, rgb2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    checks++;
    if (xpos[0] !== 11'd1)
      begin failures++; $display("FAIL lat_first_xpos got=%0d exp=1", xpos[0]); end
    for (int k = 0; k < 12; k++) begin
      rgb0 = {r[0], g[0], b[0]};
      rgb1 = {r[1], g[1], b[1]};
      rgb2 = {r[2], g[2], b[2]};
      if (k == 3) begin
        checks++;
        if (rgb0 !== 12'h000) begin failures++; $display("FAIL lat3_before got=%h exp=000", rgb0); end
      end
      if (k == 4) begin
        checks++;
        if (rgb0 !== 12'hF0A) begin failures++; $display("FAIL lat3_first got=%h exp=f0a", rgb0); end
      end
      if (k == 1) begin
        checks++;
        if (rgb1 !== 12'h000) begin failures++; $display("FAIL lat1_before got=%h exp=000", rgb1); end
      end
      if (k == 2) begin
        checks++;
        if (rgb1 !== 12'h555) begin failures++; $display("FAIL lat1_first got=%h exp=555", rgb1); end
      end
      if (k == 8) begin
        checks++;
        if (rgb2 !== 12'h000) begin failures++; $display("FAIL lat8_before got=%h exp=000", rgb2); end
      end
      if (k == 9) begin
        checks++;
        if (rgb2 !== 12'h555) begin failures++; $display("FAIL lat8_first got=%h exp=555", rgb2); end
      end
      step((k == 3) ? 12'hF0A : 12'h555);
    end
  endtask

  task automatic test_blank_forcing;
    int act_ok [3];
    int blank_bad [3];
    int lat;
    for (int d = 0; d < 3; d++) begin act_ok[d] = 0; blank_bad[d] = 0; end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    for (int k = 0; k < FT + 10; k++) begin
      for (int d = 0; d < 3; d++) begin
        lat = lat_of(d);
        if (k >= lat + 1 && k < lat + 1 + FT) begin
          if (m_active(k - lat - 1)) begin
            if ({r[d], g[d], b[d]} === 12'hFFF) act_ok[d]++;
          end else begin
            if ({r[d], g[d], b[d]} !== 12'h000) blank_bad[d]++;
          end
        end
      end
      step(12'hFFF);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (act_ok[d] != HA * VA)
        begin failures++; $display("FAIL blank_active_fff dut%0d got=%0d exp=%0d", d, act_ok[d], HA * VA); end
      checks++;
      if (blank_bad[d] != 0)
        begin failures++; $display("FAIL blank_forced_zero dut%0d nonzero_cycles=%0d exp=0", d, blank_bad[d]); end
    end
  endtask

  task automatic test_mid_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    for (int k = 0; k < 5 * HT + 10; k++) step(12'hFFF);
    checks++;
    if ({r[0], g[0], b[0]} !== 12'hFFF)
      begin failures++; $display("FAIL midrst_pre_rgb got=%h exp=fff", {r[0], g[0], b[0]}); end
    vga_data = 12'hFFF;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (xpos[d] !== 11'd0 || ypos[d] !== 11'd0)
        begin failures++; $display("FAIL midrst_pos dut%0d got x=%0d y=%0d exp 0 0", d, xpos[d], ypos[d]); end
      checks++;
      if ({hs[d], vs[d], fs[d]} !== 3'b110 || {r[d], g[d], b[d]} !== 12'h000)
        begin failures++; $display("FAIL midrst_out dut%0d got hs/vs/fs=%b rgb=%h exp 110 000", d, {hs[d], vs[d], fs[d]}, {r[d], g[d], b[d]}); end
    end
    repeat (3) @(posedge clk);
    release_reset();
    checks++;
    if (fs[0] !== 1'b1 || xpos[0] !== 11'd1 || ypos[0] !== 11'd1)
      begin failures++; $display("FAIL midrst_restart got fs=%b x=%0d y=%0d exp 1 1 1", fs[0], xpos[0], ypos[0]); end
    step(12'hFFF);
    checks++;
    if (fs[0] !== 1'b0 || xpos[0] !== 11'd2 || {r[0], g[0], b[0]} !== 12'h000)
      begin failures++; $display("FAIL midrst_cycle1 got fs=%b x=%0d rgb=%h exp 0 2 000", fs[0], xpos[0], {r[0], g[0], b[0]}); end
  endtask

  initial begin
    test_reset();
    test_raster_random();
    test_latency();
    test_blank_forcing();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_scan_driver.md
# vga_scan_driver

Display-side end of the pixel interface consumed by the game rendering blocks. Generates 640x480@60 Hz VGA raster timing from a 25 MHz pixel clock. Publishes the current pixel coordinates (`VGA_xpos`, `VGA_ypos`) to the renderers and accepts their 12-bit colour word `VGA_data` a fixed number of cycles later. Drives the registered, latency-aligned sync and RGB pins to the DAC/connector.

## Interface
- `DATA_LAT`, default 3: cycles from coordinates presented to matching `VGA_data` valid; legal range 1..8.
- `H_ACTIVE`/`H_FP`/`H_SYNC`/`H_BP`, defaults 640/16/96/48: horizontal timing in pixels.
- `V_ACTIVE`/`V_FP`/`V_SYNC`/`V_BP`, defaults 480/10/2/33: vertical timing in lines.
- `clk`, input, 1: pixel clock, 25 MHz. One clock; every register is on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `VGA_data`, input, 12: colour from renderers; [11:8]=R, [7:4]=G, [3:0]=B.
- `VGA_xpos`, output, 11: 1..640 during active columns, 0 otherwise.
- `VGA_ypos`, output, 11: 1..480 during active lines, 0 otherwise.
- `VGA_hs`, output, 1: horizontal sync, active low.
- `VGA_vs`, output, 1: vertical sync, active low.
- `VGA_r`/`VGA_g`/`VGA_b`, output, 4 each: pixel colour, forced 0 in blanking.
- `frame_start`, output, 1: one-cycle pulse when the counters are at (h=0, v=0).

## Operation
- `h_cnt` counts 0..799 and wraps to 0. `v_cnt` increments only when `h_cnt`=799, counts 0..524 and wraps to 0.
- Active region:
  - columns `h_cnt` 0..639; lines `v_cnt` 0..479.
  - `VGA_xpos` = `h_cnt`+1 when column active *and* line active, else 0. `VGA_ypos` follows the same rule using `v_cnt`.
  - Both are decoded from the counter registers only, so they are glitch-free.
- Sync windows:
  - hsync asserted for `h_cnt` 656..751.
  - vsync asserted for `v_cnt` 490..491, for whole lines.
- Alignment pipeline: a shift register of depth `DATA_LAT` carries {active, hs, vs} for each cycle's counter state.
- Output stage, registered:
  - `VGA_hs`/`VGA_vs` are the delayed sync values, inverted to active-low.
  - RGB is `VGA_data` if the delayed active bit is 1, else 12'h000.
- `VGA_data` is ignored while the delayed active bit is 0. No handshake exists; the renderers must meet `DATA_LAT` exactly.
- Width rules:
  - counters are 10 bits; coordinates are zero-extended to 11 bits.
  - there is no arithmetic overflow, since the maximum is 800.

## Timing
- Coordinates for counter state S appear in cycle n.
- `VGA_data` for S is sampled at the end of cycle n+`DATA_LAT`.
- `VGA_hs`, `VGA_vs` and RGB for S appear in cycle n+`DATA_LAT`+1, all on the same edge, so sync-to-pixel skew is 0.
- `frame_start` is undelayed: high in the cycle where `h_cnt`=0 and `v_cnt`=0.
- Reset values while `rst_n`=0:
  - `h_cnt`=`v_cnt`=0.
  - every pipeline stage holds active=0 and sync inactive.
  - `VGA_hs`=`VGA_vs`=1; RGB=0; `frame_start`=0.
  - `VGA_xpos`/`VGA_ypos`=0, because decode is gated by reset.
- Reset release:
  - first counting edge moves to `h_cnt`=1; state (0,0) is held during the first cycle after release.
  - `frame_start` pulses in that first cycle.
  - the first active pixel reaches the pins `DATA_LAT`+1 cycles after release.
- Reset mid-frame:
  - outputs go to reset values immediately, with no partial line flushed.
  - the next frame starts cleanly at (0,0).
- Wrap boundaries:
  - `h_cnt` 799→0 and `v_cnt` 524→0 happen on the same edge at frame end.
  - `v_cnt` 479→480 blanks the whole next line.

## Structure
- Package `vga_timing_pkg`: the default timing constants, derived totals `H_TOTAL`=800 and `V_TOTAL`=525, sync start/end constants, and the colour field slice positions.
- Sub-module `vga_delay_line`: parameterised-width, parameterised-depth register shift line with async active-low clear. It is used for the {active, hs, vs} alignment pipeline.
- Top: the counters, coordinate decode, output register and `frame_start` logic.

## Test plan
- Reset, then run 420000 cycles:
  - exactly one `frame_start` every 420000 cycles.
  - `VGA_hs` low for 96 cycles per 800.
  - `VGA_vs` low for 1600 cycles per frame.
- Line 0 coordinates:
  - `h_cnt`=0 → `VGA_xpos`=1; `h_cnt`=639 → 640; `h_cnt`=640 → 0.
  - `VGA_ypos`=1 throughout line 0 active.
- Latency, `DATA_LAT`=3: model returns `VGA_data`=12'hF0A three cycles after `VGA_xpos`=1.
  - `VGA_r`=F, `VGA_g`=0, `VGA_b`=A exactly 4 cycles after `VGA_xpos`=1.
  - the pixel before it is 0.
- Blank forcing: `VGA_data` held at 12'hFFF constantly → RGB is 0 in all porch, sync and vertical-blank cycles, and FFF in all 307200 active pixels.
- Async reset at (`h_cnt`=300, `v_cnt`=200):
  - outputs reach reset values without a clock edge.
  - after release the next `frame_start` occurs in the first cycle.
- Sweep `DATA_LAT`=1 and 8: sync-to-RGB alignment is still 0 skew, and first-pixel latency is `DATA_LAT`+1.
